// File: rtl/vcd_sched.sv
// vcd_sched: one-packet-in-flight VC allocator with per-VC credit counters and a sticky error flag.
// Define VCD_SCHED_RR_EN for round-robin allocation; otherwise the lowest-index VC with credit wins.
module vcd_sched #(
   parameter int VCN = 2,
   parameter int CRD = 4,
   parameter int CW  = $clog2(CRD + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_vld,
   input  logic [2:0]          in_ft,
   output logic                in_rdy,
   output logic [VCN-1:0]      divc,
   input  logic [VCN-1:0]      crd_ret,
   output logic [VCN*CW-1:0]   vc_crd,
   output logic                err
);

   localparam int            IW    = (VCN > 1) ? $clog2(VCN) : 1;
   localparam logic [CW-1:0] CRD_V = CW'(CRD);

   typedef enum logic {IDLE, XFER} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   sel_q, sel_d;
   logic            first_q, first_d;
   logic            err_q, err_d;
   logic [CW-1:0]   crd_q [VCN];
   logic [CW-1:0]   crd_d [VCN];
   logic [VCN-1:0]  has_crd;
   logic [VCN-1:0]  sat;
   logic            xfer;
   logic            alloc;
   logic            grant_vld;
   logic [IW-1:0]   grant_idx;
   logic            unused_ft_body;
`ifdef VCD_SCHED_RR_EN
   logic [IW-1:0]   ptr_q, ptr_d;
`endif

   // Body flits carry no information beyond "neither head nor tail".
   assign unused_ft_body = in_ft[1];

   for (genvar gi = 0; gi < VCN; gi++) begin : g_vc
      assign has_crd[gi]              = (crd_q[gi] != '0);
      assign vc_crd[gi*CW +: CW]      = crd_q[gi];
   end

   assign xfer  = (state_q == XFER) && in_vld && has_crd[sel_q];
   assign alloc = (state_q == IDLE) && in_vld && in_ft[0] && grant_vld;

   // Descending scan so the lowest-offset candidate is the final assignment.
   always_comb begin
      grant_vld = |has_crd;
      grant_idx = '0;
      for (int k = VCN - 1; k >= 0; k--) begin
`ifdef VCD_SCHED_RR_EN
         if (has_crd[IW'((int'(ptr_q) + k) % VCN)])
            grant_idx = IW'((int'(ptr_q) + k) % VCN);
`else
         if (has_crd[k])
            grant_idx = IW'(k);
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (alloc) state_d = XFER;
         XFER:    if (xfer && in_ft[2]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sel_d   = sel_q;
      first_d = first_q;
`ifdef VCD_SCHED_RR_EN
      ptr_d   = ptr_q;
`endif
      if (alloc) begin
         sel_d   = grant_idx;
         first_d = 1'b1;
`ifdef VCD_SCHED_RR_EN
         ptr_d   = IW'((int'(grant_idx) + 1) % VCN);
`endif
      end else if (xfer) begin
         first_d = 1'b0;
      end
   end

   // A return and a transfer on the same VC cancel; a lone return on a full VC saturates.
   always_comb begin
      for (int i = 0; i < VCN; i++) begin
         crd_d[i] = crd_q[i];
         sat[i]   = 1'b0;
         if (crd_ret[i] && !(xfer && sel_q == IW'(i))) begin
            if (crd_q[i] == CRD_V) sat[i]   = 1'b1;
            else                   crd_d[i] = crd_q[i] + 1'b1;
         end else if (!crd_ret[i] && xfer && sel_q == IW'(i)) begin
            crd_d[i] = crd_q[i] - 1'b1;
         end
      end
   end

   always_comb begin
      err_d = err_q
            | ((state_q == IDLE) && in_vld && !in_ft[0])
            | (xfer && in_ft[0] && !first_q)
            | (|sat);
   end

   always_comb begin
      in_rdy = 1'b0;
      divc   = '0;
      if (state_q == XFER) begin
         divc[sel_q] = 1'b1;
         in_rdy      = has_crd[sel_q];
      end
   end

   assign err = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q   <= '0;
         first_q <= 1'b0;
         err_q   <= 1'b0;
         for (int i = 0; i < VCN; i++) crd_q[i] <= CRD_V;
`ifdef VCD_SCHED_RR_EN
         ptr_q   <= '0;
`endif
      end else begin
         sel_q   <= sel_d;
         first_q <= first_d;
         err_q   <= err_d;
         for (int i = 0; i < VCN; i++) crd_q[i] <= crd_d[i];
`ifdef VCD_SCHED_RR_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

endmodule
